yc_line_sequencer: RTL and testbench
====================================

# yc_line_sequencer

Line-timing controller for the composite Y/C separation path. It watches the raw 12-bit composite sample stream and detects horizontal (and optionally vertical) sync. It then sequences each line through back porch, separator priming and active video. Outputs are a flush pulse for the comb/box-filter separator, a colour-burst gate, and active-video qualifiers plus pixel and line coordinates for the downstream upscaler.

## Interface
Parameters:
- SYNC_THRESH, -1024: signed 12-bit level; a sample strictly below it is a sync sample.
- SYNC_MIN_LEN, 256: minimum low run, in samples, that counts as a valid sync.
- VSYNC_MIN_LEN, 1500: minimum low run that counts as a broad (vertical) pulse.
- BACKPORCH_LEN, 350: cycles in the BACK state.
- BURST_START, 40: offset into BACK where burst_gate rises.
- BURST_LEN, 200: burst_gate width in cycles.
- PRIME_LEN, 22: separator fill time, i.e. a 21-tap window plus 1 output register.
- ACTIVE_LEN, 3840: active samples per line.
- LINE_TIMEOUT, 4800: cycles without a valid sync before a free-run line tick.
- LINES_PER_FIELD, 262: line_cnt wraps to 0 after LINES_PER_FIELD-1.

Ports:
- clk, in, 1: sample clock (74.25 MHz).
- rst, in, 1: asynchronous, active-high reset.
- sample_in, in, 12 (signed): composite sample, one per clock.
- sep_clear, out, 1: one-cycle flush pulse to the Y/C separator.
- burst_gate, out, 1: high during the burst window.
- active_out, out, 1: high for active-video samples.
- pixel_x, out, 12: index of the current active sample.
- line_cnt, out, 10: line number within the field.
- lock_lost, out, 1: sync timeout flag.
- field_start, out, 1: one-cycle pulse on a broad pulse; only driven when YC_SEQ_VSYNC_EN is defined, otherwise tied 0.

## Operation
- States are SEARCH, SYNC, BACK, PRIME and ACTIVE. Reset state is SEARCH.
- SEARCH to SYNC: on a clock where sample_in < SYNC_THRESH.
  - sync_cnt loads 1 on that clock.
  - sync_cnt is 13 bits and saturates at 8191.
- SYNC: sync_cnt increments on each further low sample.
  - On the first high sample, if sync_cnt < SYNC_MIN_LEN, the run is a glitch: return to SEARCH with no outputs.
  - Otherwise the run is a valid hsync: go to BACK, or apply the broad-pulse rule under Configuration.
- On entry to BACK (valid hsync):
  - sep_clear pulses for the first BACK cycle.
  - line_cnt increments and wraps.
  - The line timer clears.
  - lock_lost clears.
- BACK lasts BACKPORCH_LEN cycles. burst_gate is high for BACK cycle indices BURST_START to BURST_START+BURST_LEN-1, counting from 0.
- PRIME lasts PRIME_LEN cycles. No outputs are asserted.
- ACTIVE lasts ACTIVE_LEN cycles.
  - active_out is high throughout.
  - pixel_x is 0 on the first ACTIVE cycle and increments by 1 up to ACTIVE_LEN-1.
  - After the last ACTIVE cycle the FSM returns to SEARCH.
- Sync detection is evaluated only in SEARCH. Low samples during BACK, PRIME or ACTIVE do not abort the line.
- Line timer: a 13-bit counter that runs in every state and clears on each valid hsync.
  - If it reaches LINE_TIMEOUT while the FSM is in SEARCH, line_cnt ticks (with wrap), lock_lost is set and the timer clears.
  - The FSM stays in SEARCH.
- A low sample on the same clock as a timeout: the timeout tick is taken and the FSM also enters SYNC.

## Timing
- All outputs are registered decodes of state and counters.
- Reset values: state SEARCH; all counters 0; sep_clear, burst_gate, active_out and field_start are 0; pixel_x, line_cnt and lock_lost are 0.
- rst takes effect immediately, including mid-line, with no completion of the current line.
- Define t0 as the clock of the first low sample and t1 as the clock of the first high sample after it. The sync length is t1-t0.
- For a valid hsync:
  - sep_clear is high at cycle t1+1 only.
  - burst_gate is high from t1+1+BURST_START.
  - active_out first rises at t1+1+BACKPORCH_LEN+PRIME_LEN and stays high for exactly ACTIVE_LEN cycles.
- The earliest possible next SYNC entry is the cycle after the last active sample.

## Configuration
- YC_SEQ_VSYNC_EN defined: a run with sync_cnt >= VSYNC_MIN_LEN is a broad pulse. At t1+1:
  - field_start pulses.
  - line_cnt is forced to 0.
  - The timer clears.
  - The FSM returns to SEARCH with no sep_clear, BACK or ACTIVE sequence.
- YC_SEQ_VSYNC_EN undefined:
  - A broad pulse is treated as an ordinary valid hsync.
  - field_start is constant 0.
  - line_cnt only wraps at LINES_PER_FIELD.

## Test plan
- Clean line (defaults): sample_in = -2000 for 300 cycles, then 0.
  - sep_clear pulses at t1+1.
  - burst_gate is high t1+41 to t1+240.
  - active_out is high for 3840 cycles from t1+373, with pixel_x running 0 to 3839.
  - line_cnt goes 0 to 1.
- Glitch: 50 low samples then 0.
  - The FSM returns to SEARCH.
  - No sep_clear, burst_gate or active_out.
  - line_cnt is unchanged.
- Broad pulse: 2000 low samples.
  - With the macro: field_start pulses at t1+1, line_cnt = 0 and active_out never rises.
  - Without the macro: the normal line sequence runs and line_cnt increments.
- Loss of sync: constant 0 for 4800 cycles after a valid line.
  - lock_lost rises and line_cnt increments once.
  - The next valid sync clears lock_lost.
- Reset mid-ACTIVE: assert rst at pixel_x = 1000.
  - active_out and pixel_x go to 0 asynchronously.
  - After release, the FSM is in SEARCH.
- Wrap: 262 consecutive valid lines, then one more; line_cnt runs 261 to 0.

Source files
------------

// File: rtl/yc_line_sequencer.sv
// =============================================================================
// Module   : yc_line_sequencer
// Summary  : Composite line-timing FSM: sync detect, back porch/burst, separator
//            priming, active video. Broad-pulse (vertical) detection is enabled
//            by defining YC_SEQ_VSYNC_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module yc_line_sequencer #(
  parameter logic signed [11:0] SYNC_THRESH     = -12'sd1024,
  parameter int                 SYNC_MIN_LEN    = 256,
  parameter int                 VSYNC_MIN_LEN   = 1500,
  parameter int                 BACKPORCH_LEN   = 350,
  parameter int                 BURST_START     = 40,
  parameter int                 BURST_LEN       = 200,
  parameter int                 PRIME_LEN       = 22,
  parameter int                 ACTIVE_LEN      = 3840,
  parameter int                 LINE_TIMEOUT    = 4800,
  parameter int                 LINES_PER_FIELD = 262
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] sample_in,
  output logic               sep_clear,
  output logic               burst_gate,
  output logic               active_out,
  output logic        [11:0] pixel_x,
  output logic        [9:0]  line_cnt,
  output logic               lock_lost,
  output logic               field_start
);

  typedef enum logic [2:0] {
    S_SEARCH = 3'd0,
    S_SYNC   = 3'd1,
    S_BACK   = 3'd2,
    S_PRIME  = 3'd3,
    S_ACTIVE = 3'd4
  } state_t;

`ifdef YC_SEQ_VSYNC_EN
  localparam bit c_vsync_en = 1'b1;
`else
  localparam bit c_vsync_en = 1'b0;
`endif

  localparam logic [12:0] c_sync_min   = 13'(SYNC_MIN_LEN);
  localparam logic [12:0] c_vsync_min  = 13'(VSYNC_MIN_LEN);
  localparam logic [12:0] c_timeout    = 13'(LINE_TIMEOUT);
  localparam logic [11:0] c_back_last  = 12'(BACKPORCH_LEN - 1);
  localparam logic [11:0] c_prime_last = 12'(PRIME_LEN - 1);
  localparam logic [11:0] c_act_last   = 12'(ACTIVE_LEN - 1);
  localparam logic [11:0] c_burst_lo   = 12'(BURST_START);
  localparam logic [11:0] c_burst_hi   = 12'(BURST_START + BURST_LEN - 1);
  localparam logic [9:0]  c_line_last  = 10'(LINES_PER_FIELD - 1);

  state_t      state_q, state_d;
  logic [12:0] sync_cnt_q, sync_cnt_d;
  logic [12:0] timer_q, timer_d;
  logic [11:0] phase_q, phase_d;
  logic [11:0] pix_q, pix_d;
  logic [9:0]  line_q, line_d;
  logic        lock_q, lock_d;
  logic        sep_q, sep_d;
  logic        burst_q, burst_d;
  logic        active_q, active_d;
  logic        field_q, field_d;
  logic        w_low;
  logic        w_broad;

  function automatic logic [9:0] f_line_inc(input logic [9:0] l);
    return (l == c_line_last) ? 10'd0 : l + 10'd1;
  endfunction

  assign w_low   = (sample_in < SYNC_THRESH);
  assign w_broad = c_vsync_en && (sync_cnt_q >= c_vsync_min);

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    phase_d    = phase_q;
    line_d     = line_q;
    lock_d     = lock_q;
    sep_d      = 1'b0;
    field_d    = 1'b0;
    timer_d    = (timer_q == 13'h1FFF) ? timer_q : timer_q + 13'd1;

    // Free-run tick; the sync detector below still runs on the same clock.
    if (state_q == S_SEARCH && timer_q >= c_timeout) begin
      line_d  = f_line_inc(line_q);
      lock_d  = 1'b1;
      timer_d = 13'd0;
    end

    case (state_q)
      S_SEARCH: begin
        if (w_low) begin
          state_d    = S_SYNC;
          sync_cnt_d = 13'd1;
        end
      end
      S_SYNC: begin
        if (w_low) begin
          sync_cnt_d = (sync_cnt_q == 13'h1FFF) ? sync_cnt_q : sync_cnt_q + 13'd1;
        end else if (sync_cnt_q < c_sync_min) begin
          state_d = S_SEARCH;
        end else if (w_broad) begin
          state_d = S_SEARCH;
          field_d = 1'b1;
          line_d  = 10'd0;
          timer_d = 13'd0;
        end else begin
          state_d = S_BACK;
          phase_d = 12'd0;
          sep_d   = 1'b1;
          line_d  = f_line_inc(line_q);
          timer_d = 13'd0;
          lock_d  = 1'b0;
        end
      end
      S_BACK: begin
        if (phase_q == c_back_last) begin
          state_d = S_PRIME;
          phase_d = 12'd0;
        end else begin
          phase_d = phase_q + 12'd1;
        end
      end
      S_PRIME: begin
        if (phase_q == c_prime_last) begin
          state_d = S_ACTIVE;
          phase_d = 12'd0;
        end else begin
          phase_d = phase_q + 12'd1;
        end
      end
      S_ACTIVE: begin
        if (phase_q == c_act_last) begin
          state_d = S_SEARCH;
          phase_d = 12'd0;
        end else begin
          phase_d = phase_q + 12'd1;
        end
      end
      default: state_d = S_SEARCH;
    endcase

    // Decode from next-state values so the registered outputs line up with state.
    burst_d  = (state_d == S_BACK) && (phase_d >= c_burst_lo) && (phase_d <= c_burst_hi);
    active_d = (state_d == S_ACTIVE);
    pix_d    = active_d ? phase_d : 12'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_SEARCH;
      sync_cnt_q <= 13'd0;
      timer_q    <= 13'd0;
      phase_q    <= 12'd0;
      pix_q      <= 12'd0;
      line_q     <= 10'd0;
      lock_q     <= 1'b0;
      sep_q      <= 1'b0;
      burst_q    <= 1'b0;
      active_q   <= 1'b0;
      field_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      lock_q     <= lock_d;
      sep_q      <= sep_d;
      burst_q    <= burst_d;
      active_q   <= active_d;
      field_q    <= field_d;
    end
  end

  assign sep_clear   = sep_q;
  assign burst_gate  = burst_q;
  assign active_out  = active_q;
  assign pixel_x     = pix_q;
  assign line_cnt    = line_q;
  assign lock_lost   = lock_q;
  assign field_start = field_q;

endmodule

`default_nettype wire

// File: tb/tb_yc_line_sequencer.sv
// =============================================================================
// Module   : tb_yc_line_sequencer
// Summary  : Directed bench: default-parameter instance for line timing, glitch,
//            broad pulse, sync loss and reset; short-parameter instance for wrap.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_yc_line_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [11:0] samp_d = '0;
  logic signed [11:0] samp_s = '0;
  bit                 sel = 1'b0;

  logic        d_sep, d_burst, d_active, d_lock, d_field;
  logic [11:0] d_pix;
  logic [9:0]  d_line;
  logic        s_sep, s_burst, s_active, s_lock, s_field;
  logic [11:0] s_pix;
  logic [9:0]  s_line;

  logic        o_sep, o_burst, o_active, o_lock, o_field;
  logic [11:0] o_pix;
  logic [9:0]  o_line;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int t1, t1a, line_before, line_after;
  int sep_n, sep_first, burst_n, burst_first, act_n, act_first;
  int field_n, field_first, pix_first, pix_last, pix_err, lock_at1;

  always #5 clk = ~clk;

  yc_line_sequencer u_dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (samp_d),
    .sep_clear  (d_sep),
    .burst_gate (d_burst),
    .active_out (d_active),
    .pixel_x    (d_pix),
    .line_cnt   (d_line),
    .lock_lost  (d_lock),
    .field_start(d_field)
  );

  yc_line_sequencer #(
    .SYNC_MIN_LEN   (8),
    .VSYNC_MIN_LEN  (40),
    .BACKPORCH_LEN  (20),
    .BURST_START    (4),
    .BURST_LEN      (6),
    .PRIME_LEN      (4),
    .ACTIVE_LEN     (16),
    .LINE_TIMEOUT   (200),
    .LINES_PER_FIELD(262)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (samp_s),
    .sep_clear  (s_sep),
    .burst_gate (s_burst),
    .active_out (s_active),
    .pixel_x    (s_pix),
    .line_cnt   (s_line),
    .lock_lost  (s_lock),
    .field_start(s_field)
  );

  assign o_sep    = sel ? s_sep    : d_sep;
  assign o_burst  = sel ? s_burst  : d_burst;
  assign o_active = sel ? s_active : d_active;
  assign o_lock   = sel ? s_lock   : d_lock;
  assign o_field  = sel ? s_field  : d_field;
  assign o_pix    = sel ? s_pix    : d_pix;
  assign o_line   = sel ? s_line   : d_line;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for one clock; outputs are observed 1 ns after the edge.
  task automatic drive(input logic signed [11:0] v);
    if (sel) begin
      samp_s = v;
      samp_d = '0;
    end else begin
      samp_d = v;
      samp_s = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // nlow samples of lowv, then nhigh zero samples; j counts cycles after t1.
  task automatic run_line(input bit s, input int nlow, input int nhigh,
                          input logic signed [11:0] lowv);
    sel = s;
    line_before = int'(o_line);
    for (int i = 0; i < nlow; i++) drive(lowv);
    t1 = cyc;
    sep_n = 0; sep_first = -1; burst_n = 0; burst_first = -1;
    act_n = 0; act_first = -1; field_n = 0; field_first = -1;
    pix_first = -1; pix_last = -1; pix_err = 0; lock_at1 = -1;
    for (int j = 1; j <= nhigh; j++) begin
      drive(12'sd0);
      if (j == 1) lock_at1 = int'(o_lock);
      if (o_sep) begin
        sep_n++;
        if (sep_first < 0) sep_first = j;
      end
      if (o_burst) begin
        burst_n++;
        if (burst_first < 0) burst_first = j;
      end
      if (o_field) begin
        field_n++;
        if (field_first < 0) field_first = j;
      end
      if (o_active) begin
        if (act_n == 0) pix_first = int'(o_pix);
        else if (int'(o_pix) != pix_last + 1) pix_err++;
        pix_last = int'(o_pix);
        act_n++;
        if (act_first < 0) act_first = j;
      end
    end
    line_after = int'(o_line);
  endtask

  initial begin
    int err;
    #1;
    chk("rst_sep", d_sep, 0);
    chk("rst_burst", d_burst, 0);
    chk("rst_active", d_active, 0);
    chk("rst_pix", d_pix, 0);
    chk("rst_line", d_line, 0);
    chk("rst_lock", d_lock, 0);
    chk("rst_field", d_field, 0);
    do_reset();

    // Clean line, default parameters
    run_line(0, 300, 4300, -12'sd2000);
    t1a = t1;
    chk("clean_sep_n", sep_n, 1);
    chk("clean_sep_at", sep_first, 1);
    chk("clean_burst_at", burst_first, 41);
    chk("clean_burst_n", burst_n, 200);
    chk("clean_act_at", act_first, 373);
    chk("clean_act_n", act_n, 3840);
    chk("clean_pix_first", pix_first, 0);
    chk("clean_pix_last", pix_last, 3839);
    chk("clean_pix_seq", pix_err, 0);
    chk("clean_line", line_after, 1);
    chk("clean_field", field_n, 0);

    // Glitch
    run_line(0, 50, 60, -12'sd2000);
    chk("glitch_sep", sep_n, 0);
    chk("glitch_burst", burst_n, 0);
    chk("glitch_act", act_n, 0);
    chk("glitch_line", line_after, 1);

    // Loss of sync
    sel = 1'b0;
    for (int i = 0; i < 2000 && !d_lock; i++) drive(12'sd0);
    chk("loss_lock", d_lock, 1);
    chk("loss_time", int'(cyc >= t1a + 4800 && cyc <= t1a + 4803), 1);
    chk("loss_line", d_line, 2);
    for (int i = 0; i < 100; i++) drive(12'sd0);
    chk("loss_line_once", d_line, 2);

    // Next valid sync clears lock_lost
    run_line(0, 300, 4300, -12'sd2000);
    chk("relock_lock", lock_at1, 0);
    chk("relock_line", line_after, 3);
    chk("relock_act_n", act_n, 3840);

    // Broad pulse
    run_line(0, 2000, 4300, -12'sd2000);
`ifdef YC_SEQ_VSYNC_EN
    chk("broad_field_n", field_n, 1);
    chk("broad_field_at", field_first, 1);
    chk("broad_line", line_after, 0);
    chk("broad_act", act_n, 0);
    chk("broad_sep", sep_n, 0);
`else
    chk("broad_field_n", field_n, 0);
    chk("broad_sep", sep_n, 1);
    chk("broad_line", line_after, 4);
    chk("broad_act", act_n, 3840);
`endif

    // Reset in the middle of ACTIVE
    sel = 1'b0;
    for (int i = 0; i < 300; i++) drive(-12'sd2000);
    for (int i = 0; i < 2000 && !(d_active && d_pix == 12'd1000); i++) drive(12'sd0);
    chk("mid_pix", d_pix, 1000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_active", d_active, 0);
    chk("mid_rst_pix", d_pix, 0);
    chk("mid_rst_line", d_line, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    err = 0;
    for (int i = 0; i < 400; i++) begin
      drive(12'sd0);
      if (d_active || d_burst || d_sep) err++;
    end
    chk("post_rst_idle", err, 0);

    // Short-parameter instance: line timing, wrap and boundaries
    do_reset();
    err = 0;
    for (int k = 1; k <= 263; k++) begin
      run_line(1, 10, 45, -12'sd2000);
      if (k == 1) begin
        chk("s_burst_at", burst_first, 5);
        chk("s_burst_n", burst_n, 6);
        chk("s_act_at", act_first, 25);
        chk("s_act_n", act_n, 16);
        chk("s_pix_last", pix_last, 15);
      end
      if (sep_n != 1 || act_n != 16 || line_after != (line_before + 1) % 262) err++;
      if (k == 261) chk("wrap_261", line_after, 261);
      if (k == 262) chk("wrap_0", line_after, 0);
      if (k == 263) chk("wrap_1", line_after, 1);
    end
    chk("wrap_seq", err, 0);

    run_line(1, 7, 45, -12'sd2000);
    chk("min_m1_sep", sep_n, 0);
    chk("min_m1_line", line_after, 1);
    run_line(1, 8, 45, -12'sd2000);
    chk("min_sep", sep_n, 1);
    chk("min_line", line_after, 2);
    run_line(1, 20, 45, -12'sd1024);
    chk("thr_eq_sep", sep_n, 0);
    chk("thr_eq_line", line_after, 2);
    run_line(1, 10, 45, -12'sd1025);
    chk("thr_below_sep", sep_n, 1);
    chk("thr_below_line", line_after, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
